// File: rtl/tcam_filter_writer.sv
// tcam_filter_writer: programming-side controller for the TCAM snoop filter.
// Accepts INSERT/REMOVE/FLUSH commands, maintains a shadow copy of every
// entry (valid, tag, sharers) and drives the TCAM single-entry write port so
// the array contents track the shadow copy.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready command handshake (ready only in IDLE)
//   cmd_opcode          INSERT 7'b0000001, REMOVE 7'b0000111, FLUSH 7'b0011011
//   cmd_tag, cmd_nid    tag and one-hot node id of the command
//   wr_en, wr_idx, wr_valid, wr_value, wr_mask, wr_sharers  TCAM write port
//   resp_valid, resp_hit, resp_err                          completion pulse
//   occ, full           valid-entry count / all-valid flag (TCAM_WR_STATS_EN)
//
// Optional feature macro: TCAM_WR_STATS_EN adds the occ/full outputs.
module tcam_filter_writer #(
   parameter int unsigned WIDTH     = 33,
   parameter int unsigned ENTRIES   = 8,
   parameter int unsigned NID_COUNT = 4,
   parameter int unsigned IGN_LSB   = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [6:0]                  cmd_opcode,
   input  logic [WIDTH-1:0]            cmd_tag,
   input  logic [6:0]                  cmd_nid,
   output logic                        wr_en,
   output logic [$clog2(ENTRIES)-1:0]  wr_idx,
   output logic                        wr_valid,
   output logic [WIDTH-1:0]            wr_value,
   output logic [WIDTH-1:0]            wr_mask,
   output logic [NID_COUNT-1:0]        wr_sharers,
   output logic                        resp_valid,
   output logic                        resp_hit,
   output logic                        resp_err
`ifdef TCAM_WR_STATS_EN
   ,
   output logic [$clog2(ENTRIES+1)-1:0] occ,
   output logic                         full
`endif
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam logic [6:0] OP_INSERT = 7'b0000001;
   localparam logic [6:0] OP_REMOVE = 7'b0000111;
   localparam logic [6:0] OP_FLUSH  = 7'b0011011;
   localparam logic [WIDTH-1:0] MASK = (WIDTH'(1) << IGN_LSB) - WIDTH'(1);
   localparam logic [7:0] NID_OK8 = (8'd1 << NID_COUNT) - 8'd1;
   localparam logic [6:0] NID_OK  = NID_OK8[6:0];
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEARCH,
      S_WRITE,
      S_FLUSH
   } state_t;

   state_t state_q, state_d;

   logic [6:0]       op_q;
   logic [WIDTH-1:0] tag_q;
   logic [6:0]       nid_q;
   logic [IDX_W-1:0] walk_q, walk_d;

   logic                 ent_valid_q [ENTRIES];
   logic [WIDTH-1:0]     ent_tag_q   [ENTRIES];
   logic [NID_COUNT-1:0] ent_sh_q    [ENTRIES];

   logic                 wr_en_d, wr_valid_d, resp_valid_d, resp_hit_d, resp_err_d;
   logic [IDX_W-1:0]     wr_idx_d;
   logic [WIDTH-1:0]     wr_value_d;
   logic [NID_COUNT-1:0] wr_sharers_d;

   logic                 hit, free;
   logic [IDX_W-1:0]     hit_idx, free_idx;
   logic                 cmd_err;
   logic [NID_COUNT-1:0] nid_bit, new_sh;
   logic [WIDTH-1:0]     tag_m;

`ifdef TCAM_WR_STATS_EN
   logic [$clog2(ENTRIES+1)-1:0] occ_d;
`endif

   assign wr_mask = MASK;
   assign tag_m   = tag_q & ~MASK;
   assign nid_bit = nid_q[NID_COUNT-1:0];

   // Command validity: known opcode, exactly one NID bit, within tracked nodes.
   always_comb begin
      cmd_err = 1'b0;
      if (!(op_q == OP_INSERT || op_q == OP_REMOVE || op_q == OP_FLUSH))
         cmd_err = 1'b1;
      if (nid_q == 7'd0 || (nid_q & (nid_q - 7'd1)) != 7'd0)
         cmd_err = 1'b1;
      if ((nid_q & ~NID_OK) != 7'd0)
         cmd_err = 1'b1;
   end

   // Parallel compare and free-slot search; descending loop leaves lowest index.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      free     = 1'b0;
      free_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (ent_valid_q[i] && ((ent_tag_q[i] ^ tag_q) & ~MASK) == '0) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
         if (!ent_valid_q[i]) begin
            free     = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   // Next-state, next-output and shadow-update decode.
   always_comb begin
      state_d      = state_q;
      walk_d       = walk_q;
      wr_en_d      = 1'b0;
      wr_idx_d     = wr_idx;
      wr_valid_d   = wr_valid;
      wr_value_d   = wr_value;
      wr_sharers_d = wr_sharers;
      resp_valid_d = 1'b0;
      resp_hit_d   = 1'b0;
      resp_err_d   = 1'b0;
      new_sh       = ent_sh_q[hit_idx];
`ifdef TCAM_WR_STATS_EN
      occ_d        = occ;
`endif
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) state_d = S_SEARCH;
         end
         S_SEARCH: begin
            state_d = S_WRITE;
            if (cmd_err) begin
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
            end else if (op_q == OP_FLUSH) begin
               wr_en_d      = 1'b1;
               wr_idx_d     = '0;
               wr_valid_d   = 1'b0;
               wr_value_d   = '0;
               wr_sharers_d = '0;
               walk_d       = IDX_W'(1);
               state_d      = S_FLUSH;
            end else if (op_q == OP_INSERT) begin
               resp_valid_d = 1'b1;
               if (hit) begin
                  new_sh       = ent_sh_q[hit_idx] | nid_bit;
                  wr_en_d      = 1'b1;
                  wr_idx_d     = hit_idx;
                  wr_valid_d   = 1'b1;
                  wr_value_d   = tag_m;
                  wr_sharers_d = new_sh;
                  resp_hit_d   = 1'b1;
               end else if (free) begin
                  wr_en_d      = 1'b1;
                  wr_idx_d     = free_idx;
                  wr_valid_d   = 1'b1;
                  wr_value_d   = tag_m;
                  wr_sharers_d = nid_bit;
`ifdef TCAM_WR_STATS_EN
                  occ_d        = occ + 1'b1;
`endif
               end else begin
                  resp_err_d = 1'b1;
               end
            end else begin
               resp_valid_d = 1'b1;
               if (hit) begin
                  new_sh       = ent_sh_q[hit_idx] & ~nid_bit;
                  wr_en_d      = 1'b1;
                  wr_idx_d     = hit_idx;
                  wr_valid_d   = (new_sh != '0);
                  wr_value_d   = tag_m;
                  wr_sharers_d = new_sh;
                  resp_hit_d   = 1'b1;
`ifdef TCAM_WR_STATS_EN
                  if (new_sh == '0) occ_d = occ - 1'b1;
`endif
               end
            end
         end
         S_FLUSH: begin
            wr_en_d      = 1'b1;
            wr_idx_d     = walk_q;
            wr_valid_d   = 1'b0;
            wr_value_d   = '0;
            wr_sharers_d = '0;
            if (walk_q == LAST_IDX) begin
               resp_valid_d = 1'b1;
               state_d      = S_WRITE;
`ifdef TCAM_WR_STATS_EN
               occ_d        = '0;
`endif
            end else begin
               walk_d = walk_q + 1'b1;
            end
         end
         S_WRITE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, command capture, registered outputs and shadow copy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         tag_q      <= '0;
         nid_q      <= '0;
         walk_q     <= '0;
         cmd_ready  <= 1'b1;
         wr_en      <= 1'b0;
         wr_idx     <= '0;
         wr_valid   <= 1'b0;
         wr_value   <= '0;
         wr_sharers <= '0;
         resp_valid <= 1'b0;
         resp_hit   <= 1'b0;
         resp_err   <= 1'b0;
         for (int i = 0; i < ENTRIES; i++) begin
            ent_valid_q[i] <= 1'b0;
            ent_tag_q[i]   <= '0;
            ent_sh_q[i]    <= '0;
         end
`ifdef TCAM_WR_STATS_EN
         occ  <= '0;
         full <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         walk_q     <= walk_d;
         cmd_ready  <= (state_d == S_IDLE);
         wr_en      <= wr_en_d;
         wr_idx     <= wr_idx_d;
         wr_valid   <= wr_valid_d;
         wr_value   <= wr_value_d;
         wr_sharers <= wr_sharers_d;
         resp_valid <= resp_valid_d;
         resp_hit   <= resp_hit_d;
         resp_err   <= resp_err_d;
         if (state_q == S_IDLE && cmd_valid) begin
            op_q  <= cmd_opcode;
            tag_q <= cmd_tag;
            nid_q <= cmd_nid;
         end
         // Shadow follows every array write at the same edge.
         if (wr_en_d) begin
            ent_valid_q[wr_idx_d] <= wr_valid_d;
            ent_tag_q[wr_idx_d]   <= wr_value_d;
            ent_sh_q[wr_idx_d]    <= wr_sharers_d;
         end
`ifdef TCAM_WR_STATS_EN
         occ  <= occ_d;
         full <= (occ_d == ($clog2(ENTRIES+1))'(ENTRIES));
`endif
      end
   end

endmodule

// File: tb/tb_tcam_filter_writer.sv
// Self-checking bench for tcam_filter_writer: directed sequence followed by
// randomized commands, all checked against an array-based model of the filter.
module tb_tcam_filter_writer;

   localparam int unsigned WIDTH     = 33;
   localparam int unsigned ENTRIES   = 8;
   localparam int unsigned NID_COUNT = 4;
   localparam int unsigned IGN_LSB   = 0;
   localparam int unsigned IDX_W     = $clog2(ENTRIES);
   localparam logic [6:0] OP_INS = 7'b0000001;
   localparam logic [6:0] OP_REM = 7'b0000111;
   localparam logic [6:0] OP_FL  = 7'b0011011;
   localparam logic [WIDTH-1:0] MASK = (WIDTH'(1) << IGN_LSB) - WIDTH'(1);

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 cmd_valid = 1'b0;
   logic                 cmd_ready;
   logic [6:0]           cmd_opcode = '0;
   logic [WIDTH-1:0]     cmd_tag = '0;
   logic [6:0]           cmd_nid = '0;
   logic                 wr_en;
   logic [IDX_W-1:0]     wr_idx;
   logic                 wr_valid;
   logic [WIDTH-1:0]     wr_value;
   logic [WIDTH-1:0]     wr_mask;
   logic [NID_COUNT-1:0] wr_sharers;
   logic                 resp_valid, resp_hit, resp_err;
`ifdef TCAM_WR_STATS_EN
   logic [$clog2(ENTRIES+1)-1:0] occ;
   logic                         full;
`endif

   tcam_filter_writer #(
      .WIDTH(WIDTH), .ENTRIES(ENTRIES), .NID_COUNT(NID_COUNT), .IGN_LSB(IGN_LSB)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_tag(cmd_tag), .cmd_nid(cmd_nid),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_valid(wr_valid), .wr_value(wr_value),
      .wr_mask(wr_mask), .wr_sharers(wr_sharers),
      .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_err(resp_err)
`ifdef TCAM_WR_STATS_EN
      , .occ(occ), .full(full)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model of the filter contents.
   bit                   m_valid [ENTRIES];
   logic [WIDTH-1:0]     m_tag   [ENTRIES];
   logic [NID_COUNT-1:0] m_sh    [ENTRIES];

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = '0;
         m_sh[i]    = '0;
      end
   endtask

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < ENTRIES; i++) if (m_valid[i]) n++;
      return n;
   endfunction

   task automatic check_stats(input string name);
`ifdef TCAM_WR_STATS_EN
      check({name, ":occ"}, 64'(occ), 64'(model_count()));
      check({name, ":full"}, 64'(full), 64'(model_count() == ENTRIES));
`else
      if (name.len() < 0) $display("%s", name);
`endif
   endtask

   // Applies the filter rules to the model; reports the expected write/response.
   task automatic model_cmd(input logic [6:0] op, input logic [WIDTH-1:0] tag,
                            input logic [6:0] nid, output logic e_wr,
                            output int e_idx, output logic e_valid,
                            output logic [NID_COUNT-1:0] e_sh,
                            output logic e_hit, output logic e_err);
      int setbit = 0;
      int m = -1;
      int f = -1;
      logic [NID_COUNT-1:0] bitv;
      e_wr = 0; e_idx = 0; e_valid = 0; e_sh = '0; e_hit = 0; e_err = 0;
      if (!(op == OP_INS || op == OP_REM || op == OP_FL)) e_err = 1;
      if ($countones(nid) != 1) e_err = 1;
      else begin
         for (int i = 0; i < 7; i++) if (nid[i]) setbit = i;
         if (setbit >= NID_COUNT) e_err = 1;
      end
      if (e_err || op == OP_FL) return;
      bitv = NID_COUNT'(1) << setbit;
      for (int i = 0; i < ENTRIES; i++)
         if (m < 0 && m_valid[i] && (m_tag[i] & ~MASK) == (tag & ~MASK)) m = i;
      if (op == OP_INS) begin
         if (m >= 0) begin
            m_sh[m] = m_sh[m] | bitv;
            e_hit = 1; e_wr = 1; e_idx = m; e_valid = 1; e_sh = m_sh[m];
         end else begin
            for (int i = 0; i < ENTRIES; i++) if (f < 0 && !m_valid[i]) f = i;
            if (f < 0) e_err = 1;
            else begin
               m_valid[f] = 1; m_tag[f] = tag & ~MASK; m_sh[f] = bitv;
               e_wr = 1; e_idx = f; e_valid = 1; e_sh = bitv;
            end
         end
      end else if (m >= 0) begin
         m_sh[m] = m_sh[m] & ~bitv;
         if (m_sh[m] == '0) m_valid[m] = 0;
         e_hit = 1; e_wr = 1; e_idx = m; e_valid = m_valid[m]; e_sh = m_sh[m];
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("ready_wait", 64'(cmd_ready), 64'd1);
   endtask

   task automatic do_cmd(input logic [6:0] op, input logic [WIDTH-1:0] tag,
                         input logic [6:0] nid, input string name);
      logic e_wr, e_valid, e_hit, e_err;
      int e_idx;
      logic [NID_COUNT-1:0] e_sh;
      wait_ready();
      model_cmd(op, tag, nid, e_wr, e_idx, e_valid, e_sh, e_hit, e_err);
      cmd_valid = 1; cmd_opcode = op; cmd_tag = tag; cmd_nid = nid;
      @(posedge clk); #1;
      cmd_valid = 0;
      check({name, ":ready_drop"}, 64'(cmd_ready), 64'd0);
      check({name, ":search_wr_en"}, 64'(wr_en), 64'd0);
      @(posedge clk); #1;
      check({name, ":wr_en"}, 64'(wr_en), 64'(e_wr));
      check({name, ":resp_valid"}, 64'(resp_valid), 64'd1);
      check({name, ":resp_hit"}, 64'(resp_hit), 64'(e_hit));
      check({name, ":resp_err"}, 64'(resp_err), 64'(e_err));
      if (e_wr) begin
         check({name, ":wr_idx"}, 64'(wr_idx), 64'(e_idx));
         check({name, ":wr_valid"}, 64'(wr_valid), 64'(e_valid));
         check({name, ":wr_sharers"}, 64'(wr_sharers), 64'(e_sh));
         check({name, ":wr_value"}, 64'(wr_value), 64'(tag & ~MASK));
      end
      @(posedge clk); #1;
      check({name, ":wr_en_end"}, 64'(wr_en), 64'd0);
      check({name, ":resp_end"}, 64'(resp_valid), 64'd0);
      check({name, ":ready_back"}, 64'(cmd_ready), 64'd1);
      check_stats(name);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, ":cmd_ready"}, 64'(cmd_ready), 64'd1);
      check({name, ":wr_en"}, 64'(wr_en), 64'd0);
      check({name, ":resp_valid"}, 64'(resp_valid), 64'd0);
      check({name, ":resp_hit"}, 64'(resp_hit), 64'd0);
      check({name, ":resp_err"}, 64'(resp_err), 64'd0);
      check({name, ":wr_idx"}, 64'(wr_idx), 64'd0);
      check({name, ":wr_valid"}, 64'(wr_valid), 64'd0);
      check({name, ":wr_value"}, 64'(wr_value), 64'd0);
      check({name, ":wr_sharers"}, 64'(wr_sharers), 64'd0);
      check({name, ":wr_mask"}, 64'(wr_mask), 64'(MASK));
      check_stats(name);
   endtask

   // FLUSH walk; optionally asserts reset while idx 3 is being written.
   task automatic do_flush(input bit reset_at3, input string name);
      wait_ready();
      cmd_valid = 1; cmd_opcode = OP_FL; cmd_tag = '0; cmd_nid = 7'b0000001;
      @(posedge clk); #1;
      cmd_valid = 0;
      @(posedge clk); #1;
      for (int k = 0; k < ENTRIES; k++) begin
         check({name, ":walk_wr_en"}, 64'(wr_en), 64'd1);
         check({name, ":walk_idx"}, 64'(wr_idx), 64'(k));
         check({name, ":walk_valid"}, 64'(wr_valid), 64'd0);
         check({name, ":walk_sharers"}, 64'(wr_sharers), 64'd0);
         check({name, ":walk_resp"}, 64'(resp_valid), 64'(k == ENTRIES - 1));
         check({name, ":walk_hit"}, 64'(resp_hit), 64'd0);
         if (reset_at3 && k == 3) begin
            reset = 0;
            #1;
            model_clear();
            check_reset_outputs({name, ":abort"});
            repeat (2) @(posedge clk);
            #2;
            reset = 1;
            for (int c = 0; c < 4; c++) begin
               @(posedge clk); #1;
               check({name, ":post_abort_wr_en"}, 64'(wr_en), 64'd0);
               check({name, ":post_abort_resp"}, 64'(resp_valid), 64'd0);
            end
            return;
         end
         @(posedge clk); #1;
      end
      model_clear();
      check({name, ":end_wr_en"}, 64'(wr_en), 64'd0);
      check({name, ":end_ready"}, 64'(cmd_ready), 64'd1);
      check_stats(name);
   endtask

   function automatic logic [6:0] good_nid();
      return 7'(1) << $urandom_range(NID_COUNT - 1, 0);
   endfunction

   initial begin
      logic [WIDTH-1:0] pool [6];
      logic [6:0] bad_nids [4];
      logic [WIDTH-1:0] t1;
      int r;
      bad_nids[0] = 7'b0000011; bad_nids[1] = 7'b0100000;
      bad_nids[2] = 7'b0000000; bad_nids[3] = 7'b1000000;
      model_clear();

      // Reset state
      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      reset = 1;
      @(posedge clk); #1;

      // Insert, hit-insert, removes, reallocation
      t1 = 33'h1_2345_6789;
      do_cmd(OP_INS, t1, 7'b0000010, "ins_first");
      do_cmd(OP_INS, t1, 7'b0001000, "ins_hit");
      do_cmd(OP_INS, t1, 7'b0001000, "ins_dup");
      do_cmd(OP_REM, t1, 7'b0000010, "rem_one");
      do_cmd(OP_REM, t1, 7'b0001000, "rem_last");
      do_cmd(OP_REM, t1, 7'b0001000, "rem_miss");
      do_cmd(OP_INS, 33'h0_dead_beef, 7'b0000100, "ins_realloc");

      // Fill all entries, ninth insert overflows
      do_flush(1'b0, "flush_a");
      for (int i = 0; i < 9; i++)
         do_cmd(OP_INS, 33'h0_0000_1000 + WIDTH'(i), 7'b0000001, "fill");

      // Rejected commands leave the shadow unchanged
      do_cmd(OP_REM, 33'h0_0000_1002, 7'b0000011, "err_nid_multi");
      do_cmd(OP_REM, 33'h0_0000_1002, 7'b0100000, "err_nid_range");
      do_cmd(7'b1111111, 33'h0_0000_1002, 7'b0000001, "err_opcode");
      do_cmd(OP_REM, 33'h0_0000_1002, 7'b0000001, "rem_after_err");
      do_cmd(OP_INS, 33'h1_ffff_0000, 7'b0000010, "ins_into_freed");

      // Flush after three inserts, then flush aborted by reset at idx 3
      do_flush(1'b0, "flush_b");
      for (int i = 0; i < 3; i++)
         do_cmd(OP_INS, 33'h0_0abc_0000 + WIDTH'(i), 7'b0000100, "ins3");
      do_flush(1'b0, "flush_c");
      for (int i = 0; i < 3; i++)
         do_cmd(OP_INS, 33'h0_0abc_0000 + WIDTH'(i), 7'b0000100, "ins3b");
      do_flush(1'b1, "flush_rst");
      do_cmd(OP_INS, 33'h0_0abc_0001, 7'b0000001, "ins_after_rst");

      // Randomized traffic over a small tag pool
      for (int i = 0; i < 6; i++) pool[i] = {1'($urandom_range(1, 0)), $urandom()};
      for (int n = 0; n < 120; n++) begin
         r = $urandom_range(99, 0);
         if (r < 50)
            do_cmd(OP_INS, pool[$urandom_range(5, 0)], good_nid(), "rnd_ins");
         else if (r < 85)
            do_cmd(OP_REM, pool[$urandom_range(5, 0)], good_nid(), "rnd_rem");
         else if (r < 89)
            do_flush(1'b0, "rnd_flush");
         else if (r < 95)
            do_cmd($urandom_range(1, 0) ? OP_INS : OP_REM, pool[$urandom_range(5, 0)],
                   bad_nids[$urandom_range(3, 0)], "rnd_bad_nid");
         else
            do_cmd(7'h55, pool[$urandom_range(5, 0)], good_nid(), "rnd_bad_op");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/tcam_filter_writer.md
Name: tcam_filter_writer

Overview:
Programming-side controller for the TCAM snoop filter: the writer that fills the entries the lookup side reads.
- Accepts INSERT/REMOVE/FLUSH commands, each carrying a 33-bit tag and a one-hot NID.
- Keeps a shadow copy of every filter entry: valid, tag, sharer vector.
- Drives a single-entry write port into the TCAM array, so the array's per-NID flag outputs match the shadow copy.
- Sits between the coherence request path and the TCAM filter's write side.

Parameters:
WIDTH, 33, tag width in bits.
ENTRIES, 8, number of TCAM entries (power of 2, at least 2).
NID_COUNT, 4, number of tracked nodes = sharer vector width.
IGN_LSB, 0, low tag bits masked as don't-care on compare and write (0 to WIDTH-1).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command valid.
cmd_ready  out  1  command accept; high only in IDLE.
cmd_opcode  in  7  7'b0000001 INSERT, 7'b0000111 REMOVE, 7'b0011011 FLUSH.
cmd_tag  in  WIDTH  tag to insert or remove.
cmd_nid  in  7  one-hot node id; bit i maps to sharer i.
wr_en  out  1  one-cycle TCAM entry write strobe.
wr_idx  out  $clog2(ENTRIES)  entry index being written.
wr_valid  out  1  entry valid bit written.
wr_value  out  WIDTH  entry tag; masked bits forced to 0.
wr_mask  out  WIDTH  don't-care mask; low IGN_LSB bits = 1.
wr_sharers  out  NID_COUNT  sharer vector written.
resp_valid  out  1  one-cycle command completion pulse.
resp_hit  out  1  tag matched an existing valid entry.
resp_err  out  1  command rejected; no write performed.

Behaviour:
- Reset (reset=0, asynchronous): all shadow entries invalid, sharers 0, FSM in IDLE. Outputs: cmd_ready=1, wr_en=0, resp_valid=0, resp_hit=0, resp_err=0, wr_idx/wr_value/wr_sharers/wr_valid=0. wr_mask stays at its constant.
- Handshake: a command is accepted on the clk edge where cmd_valid and cmd_ready are both 1. Opcode, tag and NID are registered at accept. cmd_ready drops the following cycle.
- FSM states: IDLE, SEARCH, WRITE, FLUSH_WALK.
- IDLE -> SEARCH on accept.
- SEARCH (1 cycle): parallel compare of the registered tag against all valid entries, with the masked bits ignored.
  - Error checks: unknown opcode; NID not one-hot; NID set bit index >= NID_COUNT.
  - On error: no write, resp_valid=1, resp_err=1 in WRITE cycle.
- INSERT:
  - Hit: OR the sharer bit into the matched entry and write it back. resp_hit=1.
  - Miss: allocate the lowest-index invalid entry with sharers = the NID bit, valid=1.
  - Miss with all entries valid: resp_err=1, no write.
  - INSERT of a sharer already set: hit, write still issued with an unchanged vector.
- REMOVE:
  - Hit: clear the sharer bit. If the resulting vector is 0, write valid=0 and sharers=0, freeing the entry. resp_hit=1.
  - Miss: no write, resp_hit=0, resp_err=0.
- WRITE (1 cycle): wr_en pulses if a write is required; resp_valid pulses. The shadow copy updates at the same edge. Return to IDLE.
- Latency: accept at edge N; wr_en and resp_valid are high in the cycle after edge N+1; cmd_ready is high again after edge N+2. Throughput is 1 command per 3 cycles.
- FLUSH: SEARCH -> FLUSH_WALK, which writes valid=0, sharers=0 to idx 0..ENTRIES-1, one per cycle (wr_en high for ENTRIES cycles). resp_valid pulses with the last write; resp_hit=0. Back to IDLE after the last write.
- At most one match exists by construction. If multiple entries match, the lowest index is used.
- Reset asserted mid-command or mid-flush: abort immediately; no further wr_en, no response.
- wr_value = cmd_tag with masked bits zeroed. Stored tags are compared only on unmasked bits.

Optional Feature:
TCAM_WR_STATS_EN:
- When defined, adds output occ [$clog2(ENTRIES+1)]: count of valid entries.
  - +1 on an allocating INSERT.
  - -1 on a freeing REMOVE.
  - 0 after FLUSH completes.
  - 0 at reset.
  - Updates at the WRITE edge.
- Also adds output full = (occ == ENTRIES).
- When not defined, neither port exists and no counter logic is built.

Test Plan:
1. Reset, then INSERT tag 33'h1_2345_6789, NID 7'b0000010 -> in the cycle after edge N+1: wr_en=1, wr_idx=0, wr_valid=1, wr_sharers=4'b0010, resp_hit=0, resp_err=0.
2. Same tag, INSERT NID 7'b0001000 -> wr_idx=0, wr_sharers=4'b1010, resp_hit=1.
3. REMOVE that tag with NID 7'b0000010, then NID 7'b0001000 -> writes sharers 4'b1000 (valid=1), then sharers 4'b0000 (valid=0). A following INSERT of a new tag reallocates idx 0.
4. INSERT 9 distinct tags -> idx 0..7 allocated; the 9th gives resp_err=1 and wr_en=0. occ=8 and full=1 when TCAM_WR_STATS_EN is defined.
5. Error commands, each -> resp_err=1, no wr_en, no shadow change:
   - NID 7'b0000011.
   - NID 7'b0100000 (bit index beyond NID_COUNT).
   - Opcode 7'b1111111.
6. FLUSH after 3 inserts -> wr_en high 8 consecutive cycles, idx 0..7, all valid=0, resp_valid on the last one. Asserting reset during the walk at idx 3 -> wr_en=0 immediately and all outputs at reset values.
